// File: rtl/alu_batch_seq.sv
// Batch sequencer: walks an opcode list in data memory, fetches operand pairs,
// feeds a combinational ALU and writes each result back to a destination region.
// Stops on an all-ones opcode word or after MAX_OPS operations.
module alu_batch_seq #(
  parameter int DW       = 32,
  parameter int AW       = 8,
  parameter int OPW      = 5,
  parameter int OP_BASE  = 0,
  parameter int A_BASE   = 64,
  parameter int B_BASE   = 128,
  parameter int DST_BASE = 192,
  parameter int MAX_OPS  = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           mem_en,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_y,
  output logic           busy,
  output logic           done,
  output logic [AW:0]    op_count,
  output logic           limit_hit
);

  typedef enum logic [2:0] {
    IDLE, RD_OP, CHK, LD_A, LD_B, WR, DONE
  } state_t;

  localparam logic [AW-1:0] OP_B   = AW'(OP_BASE);
  localparam logic [AW-1:0] A_B    = AW'(A_BASE);
  localparam logic [AW-1:0] B_B    = AW'(B_BASE);
  localparam logic [AW-1:0] DST_B  = AW'(DST_BASE);
  localparam logic [AW:0]   MAX_IX = (AW+1)'(MAX_OPS);

  state_t        state;
  logic [AW:0]   idx;
  logic [AW:0]   idx_nxt;
  logic [AW-1:0] ofs;
  logic          sentinel;

  assign idx_nxt  = idx + (AW+1)'(1);
  assign ofs      = idx[AW-1:0];
  assign sentinel = (mem_rdata == '1);

  // Sequencer state, index, counters and registered ALU operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      op_count  <= '0;
      limit_hit <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= '0;
            op_count  <= '0;
            limit_hit <= 1'b0;
            state     <= RD_OP;
          end
        end
        RD_OP: state <= CHK;
        CHK: begin
          if (sentinel) begin
            state <= DONE;
          end else begin
            alu_op <= mem_rdata[OPW-1:0];
            state  <= LD_A;
          end
        end
        LD_A: begin
          alu_a <= mem_rdata;
          state <= LD_B;
        end
        LD_B: begin
          alu_b <= mem_rdata;
          state <= WR;
        end
        WR: begin
          idx      <= idx_nxt;
          op_count <= op_count + (AW+1)'(1);
          if (idx_nxt == MAX_IX) begin
            limit_hit <= 1'b1;
            state     <= DONE;
          end else begin
            state <= RD_OP;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes decoded from state and idx; the operand-A read in CHK is
  // suppressed when the fetched opcode is the sentinel
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      RD_OP: begin
        mem_en   = 1'b1;
        mem_addr = OP_B + ofs;
      end
      CHK: begin
        if (!sentinel) begin
          mem_en   = 1'b1;
          mem_addr = A_B + ofs;
        end
      end
      LD_A: begin
        mem_en   = 1'b1;
        mem_addr = B_B + ofs;
      end
      WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = DST_B + ofs;
        mem_wdata = alu_y;
      end
      default: ;
    endcase
  end

  // Status flags
  always_comb begin
    busy = (state == RD_OP) || (state == CHK) || (state == LD_A) ||
           (state == LD_B)  || (state == WR);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_alu_batch_seq.sv
// Bench for alu_batch_seq: two instances (MAX_OPS=3, and DST_BASE=254 for
// address wrap), each with a one-cycle-latency memory and a small ALU model.
module tb_alu_batch_seq;

  localparam logic [31:0] SENT = 32'hFFFF_FFFF;
  localparam logic [4:0]  ADD = 5'd1, SUB = 5'd2, XOR_ = 5'd3;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [7:0]  addr;
    int          cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start0, en0, we0, busy0, done0, lim0;
  logic [7:0]  addr0;
  logic [31:0] wdata0, rdata0, a0, b0, y0;
  logic [4:0]  op0;
  logic [8:0]  cnt0;

  logic        start1, en1, we1, busy1, done1, lim1;
  logic [7:0]  addr1;
  logic [31:0] wdata1, rdata1, a1, b1, y1;
  logic [4:0]  op1;
  logic [8:0]  cnt1;

  logic        ld_en;
  int          ld_inst;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  wr_t  wlog0[$], wlog1[$];
  int   dlog0[$], dlog1[$];
  int   bfirst0, blast0, bn0;
  time  t0;
  int   checks = 0;
  int   failures = 0;

  alu_batch_seq #(.MAX_OPS(3)) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .mem_en(en0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0), .mem_rdata(rdata0),
    .alu_op(op0), .alu_a(a0), .alu_b(b0), .alu_y(y0),
    .busy(busy0), .done(done0), .op_count(cnt0), .limit_hit(lim0)
  );

  alu_batch_seq #(.DST_BASE(254)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .mem_en(en1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1),
    .alu_op(op1), .alu_a(a1), .alu_b(b1), .alu_y(y1),
    .busy(busy1), .done(done1), .op_count(cnt1), .limit_hit(lim1)
  );

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      XOR_:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign y0 = alu_f(op0, a0, b0);
  assign y1 = alu_f(op1, a1, b1);

  // memories: one-cycle read latency, plus a bench load port
  always @(posedge clk) begin
    if (ld_en && ld_inst == 0) mem0[ld_addr] <= ld_data;
    else if (en0) begin
      if (we0) mem0[addr0] <= wdata0;
      else     rdata0 <= mem0[addr0];
    end
  end

  always @(posedge clk) begin
    if (ld_en && ld_inst == 1) mem1[ld_addr] <= ld_data;
    else if (en1) begin
      if (we1) mem1[addr1] <= wdata1;
      else     rdata1 <= mem1[addr1];
    end
  end

  // activity logs; cycle 1 is the cycle after the edge that samples start
  always @(negedge clk) begin
    int c;
    c = int'(($time - t0 + 5) / 10);
    if (en0 && we0) wlog0.push_back('{addr0, wdata0, c});
    if (done0) dlog0.push_back(c);
    if (busy0) begin
      if (bn0 == 0) bfirst0 = c;
      blast0 = c;
      bn0++;
    end
    if (en1 && we1) wlog1.push_back('{addr1, wdata1, c});
    if (done1) dlog1.push_back(c);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic poke(input int inst, input int a, input logic [31:0] d);
    @(negedge clk);
    ld_inst = inst;
    ld_addr = 8'(a);
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic go(input int inst);
    @(negedge clk);
    wlog0.delete(); dlog0.delete(); wlog1.delete(); dlog1.delete();
    bn0 = 0; bfirst0 = -1; blast0 = -1;
    if (inst == 0) start0 = 1'b1;
    else           start1 = 1'b1;
    @(posedge clk);
    t0 = $time;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_wr0(input string name, input int i, input int addr,
                         input logic [31:0] data, input int cyc);
    if (i < wlog0.size()) begin
      chk({name, "_addr"}, 64'(wlog0[i].addr), 64'(addr));
      chk({name, "_data"}, 64'(wlog0[i].data), 64'(data));
      chk({name, "_cyc"},  64'(wlog0[i].cyc),  64'(cyc));
    end else begin
      chk({name, "_present"}, 64'(0), 64'(1));
    end
  endtask

  task automatic chk_done0(input string name, input int cyc);
    chk({name, "_ndone"}, 64'(dlog0.size()), 64'(1));
    if (dlog0.size() > 0) chk({name, "_done_cyc"}, 64'(dlog0[0]), 64'(cyc));
  endtask

  task automatic load_two_ops;
    poke(0, 0, 32'(ADD)); poke(0, 64, 32'd3);  poke(0, 128, 32'd4);
    poke(0, 1, 32'(SUB)); poke(0, 65, 32'd10); poke(0, 129, 32'd7);
    poke(0, 2, SENT);
  endtask

  vec_t tbl[3];

  initial begin
    tbl[0] = '{ADD,  32'h10,   32'h20,   32'h30,        8'd254, 5};
    tbl[1] = '{SUB,  32'd5,    32'd9,    32'hFFFF_FFFC, 8'd255, 10};
    tbl[2] = '{XOR_, 32'hF0F0, 32'hFF00, 32'h0000_0FF0, 8'd0,   15};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ld_en = 1'b0;
    ld_inst = 0; ld_addr = '0; ld_data = '0; t0 = 0;
    bn0 = 0; bfirst0 = -1; blast0 = -1;
    #12;
    chk("rst_state", {en0, we0, busy0, done0, lim0, addr0, cnt0, op0},
        64'(0));
    chk("rst_data", {wdata0, a0 | b0}, 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // two operations, sentinel at index 2
    load_two_ops();
    go(0);
    cycles(20);
    chk("two_nwr", 64'(wlog0.size()), 64'(2));
    chk_wr0("two_w0", 0, 192, 32'd7, 5);
    chk_wr0("two_w1", 1, 193, 32'd3, 10);
    chk_done0("two", 13);
    chk("two_count", 64'(cnt0), 64'(2));
    chk("two_limit", 64'(lim0), 64'(0));
    chk("two_hold_ops", {27'(0), op0, a0}, {27'(0), SUB, 32'd10});
    chk("two_hold_b", 64'(b0), 64'(7));
    chk("two_mem193", 64'(mem0[193]), 64'(3));
    chk("two_idle", {busy0, done0, en0}, 64'(0));

    // sentinel at index 0
    poke(0, 0, SENT);
    go(0);
    cycles(10);
    chk("sent_nwr", 64'(wlog0.size()), 64'(0));
    chk_done0("sent", 3);
    chk("sent_count", 64'(cnt0), 64'(0));
    chk("sent_busy_n", 64'(bn0), 64'(2));
    chk("sent_busy_span", {32'(bfirst0), 32'(blast0)}, {32'd1, 32'd2});

    // MAX_OPS=3 with no sentinel reachable
    poke(0, 0, 32'(ADD));  poke(0, 64, 32'd1); poke(0, 128, 32'd10);
    poke(0, 1, 32'(SUB));  poke(0, 65, 32'd2); poke(0, 129, 32'd20);
    poke(0, 2, 32'(XOR_)); poke(0, 66, 32'd3); poke(0, 130, 32'd30);
    poke(0, 3, 32'(ADD));
    go(0);
    cycles(25);
    chk("max_nwr", 64'(wlog0.size()), 64'(3));
    chk_wr0("max_w0", 0, 192, 32'd11, 5);
    chk_wr0("max_w1", 1, 193, 32'hFFFF_FFEE, 10);
    chk_wr0("max_w2", 2, 194, 32'h1D, 15);
    chk_done0("max", 16);
    chk("max_count", 64'(cnt0), 64'(3));
    chk("max_limit", 64'(lim0), 64'(1));
    poke(0, 0, SENT);
    go(0);
    chk("max_restart_clr", {lim0, cnt0}, 64'(0));
    cycles(10);
    chk("max_restart_lim", 64'(lim0), 64'(0));

    // reset asserted in LD_B of operation 1 (cycle 9)
    load_two_ops();
    poke(0, 193, 32'hDEAD_BEEF);
    go(0);
    cycles(8);
    rst = 1'b1;
    #1;
    chk("mid_rst_strobes", {en0, we0, busy0, done0, lim0, addr0, cnt0, op0}, 64'(0));
    chk("mid_rst_data", {wdata0, a0 | b0}, 64'(0));
    cycles(3);
    rst = 1'b0;
    cycles(15);
    chk("mid_rst_nwr", 64'(wlog0.size()), 64'(1));
    chk("mid_rst_ndone", 64'(dlog0.size()), 64'(0));
    chk("mid_rst_mem193", 64'(mem0[193]), 64'hDEAD_BEEF);
    go(0);
    cycles(20);
    chk_wr0("rerun_w0", 0, 192, 32'd7, 5);
    chk_wr0("rerun_w1", 1, 193, 32'd3, 10);
    chk_done0("rerun", 13);

    // start pulsed repeatedly during a batch, held through DONE
    go(0);
    for (int i = 2; i <= 13; i++) begin
      @(negedge clk);
      start0 = (i % 2 == 1) || (i == 13);
    end
    @(negedge clk);
    start0 = 1'b0;
    cycles(20);
    chk("rep_nwr", 64'(wlog0.size()), 64'(2));
    chk_done0("rep", 13);
    chk("rep_busy_n", 64'(bn0), 64'(12));
    chk("rep_idle", {busy0, en0}, 64'(0));

    // destination wrap-around on the DST_BASE=254 instance
    for (int i = 0; i < 3; i++) begin
      poke(1, i, 32'(tbl[i].op));
      poke(1, 64 + i, tbl[i].a);
      poke(1, 128 + i, tbl[i].b);
    end
    poke(1, 3, SENT);
    go(1);
    cycles(25);
    chk("wrap_nwr", 64'(wlog1.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < wlog1.size()) begin
        chk($sformatf("wrap_addr%0d", i), 64'(wlog1[i].addr), 64'(tbl[i].addr));
        chk($sformatf("wrap_data%0d", i), 64'(wlog1[i].data), 64'(tbl[i].y));
        chk($sformatf("wrap_cyc%0d", i),  64'(wlog1[i].cyc),  64'(tbl[i].cyc));
      end else begin
        chk($sformatf("wrap_present%0d", i), 64'(0), 64'(1));
      end
    end
    chk("wrap_ndone", 64'(dlog1.size()), 64'(1));
    if (dlog1.size() > 0) chk("wrap_done_cyc", 64'(dlog1[0]), 64'(18));
    chk("wrap_count", 64'(cnt1), 64'(3));
    chk("wrap_limit", 64'(lim1), 64'(0));
    chk("wrap_mem0", 64'(mem1[0]), 64'h0FF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_batch_seq.md
# alu_batch_seq

Parametrised batch sequencer that drives a single-port synchronous data memory and a combinational ALU. On a start pulse it walks an opcode list, fetches operand A and operand B from separate memory regions, and presents them to the ALU. It writes each result to a destination region. It stops on a sentinel opcode or after a configurable maximum operation count, then reports completion with a done pulse and the operation count. It sits between the shared data RAM and the ALU datapath.

## Interface
- DW, 32, data width of memory words and ALU operands.
- AW, 8, memory address width.
- OPW, 5, ALU opcode width, OPW <= DW.
- OP_BASE, 0, first opcode address.
- A_BASE, 64, first operand-A address.
- B_BASE, 128, first operand-B address.
- DST_BASE, 192, first result address.
- MAX_OPS, 64, operation limit, 1..2^AW.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin batch; sampled only in IDLE.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable; valid only with mem_en.
- mem_addr  out  AW  access address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data; valid the cycle after a read strobe.
- alu_op  out  OPW  registered opcode.
- alu_a, alu_b  out  DW  registered operands.
- alu_y  in  DW  ALU result; combinational from alu_op, alu_a and alu_b.
- busy  out  1  batch in progress.
- done  out  1  one-cycle completion pulse.
- op_count  out  AW+1  results written in the current or last batch.
- limit_hit  out  1  sticky; the batch ended on MAX_OPS rather than on the sentinel.

## Operation
- States: IDLE, RD_OP, CHK, LD_A, LD_B, WR, DONE. Moore outputs decode from the state and the index register idx (AW+1 bits).
- IDLE: all memory strobes low. start=1 clears idx, op_count and limit_hit, then goes to RD_OP.
- RD_OP: issue a read at mem_addr = OP_BASE+idx. Go to CHK.
- CHK: if mem_rdata is all-ones (DW bits), go to DONE. Otherwise:
  - latch alu_op <= mem_rdata[OPW-1:0];
  - issue a read at A_BASE+idx;
  - go to LD_A.
- LD_A: latch alu_a <= mem_rdata, issue a read at B_BASE+idx, go to LD_B.
- LD_B: latch alu_b <= mem_rdata, no access, go to WR.
- WR: mem_en=1, mem_we=1, mem_addr=DST_BASE+idx, mem_wdata=alu_y. Then idx++ and op_count++.
  - If the new idx equals MAX_OPS: set limit_hit and go to DONE.
  - Otherwise go to RD_OP.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Address arithmetic: base + idx[AW-1:0], truncated to AW bits, so the address wraps modulo 2^AW with no error.
- Output values outside active states: mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0 whenever the state is not issuing an access.
- busy=1 in RD_OP through WR; busy=0 in IDLE and DONE.
- start asserted while not in IDLE is ignored; it is not queued.
- alu_op, alu_a, alu_b, op_count and limit_hit hold their values after DONE until the next start clears them. alu_* are not cleared by start.
- Reset, at any time including mid-batch: the block goes to IDLE immediately. All outputs and registers go to 0.
  - A write in progress in WR is abandoned.
  - No done pulse is produced.

## Timing
- Start is sampled at edge 0. RD_OP occupies cycle 1.
- Operation k (0-based) occupies cycles 5k+1 to 5k+5. Its write is in cycle 5k+5.
- Throughput is 5 cycles per operation.
- Sentinel at list index N: CHK in cycle 5N+2, DONE in cycle 5N+3, IDLE from cycle 5N+4.
- MAX_OPS termination: the last write is in cycle 5·MAX_OPS. DONE follows in cycle 5·MAX_OPS+1.
- The memory model must return mem_rdata one cycle after a read with mem_we=0. The ALU must settle within one cycle.

## Test plan
- Two operations:
  - Memory setup: OP[0]=add, A[0]=3, B[0]=4, OP[1]=sub, A[1]=10, B[1]=7, OP[2]=0xFFFFFFFF.
  - Required: mem[192]=7 written in cycle 5 and mem[193]=3 written in cycle 10.
  - Required: done in cycle 13, op_count=2, limit_hit=0.
- Sentinel at OP[0]: no write strobe occurs, done in cycle 3, op_count=0, busy high only in cycles 1-2.
- MAX_OPS=3 with no sentinel in the list: exactly 3 writes, to addresses 192-194. Then done with op_count=3 and limit_hit=1. A following start clears limit_hit.
- Reset asserted in LD_B of operation 1:
  - all outputs go to 0 immediately;
  - no write to 193 occurs;
  - no done pulse is produced;
  - a new start reruns from index 0.
- start pulsed repeatedly during a batch: the batch is unaffected, exactly one done pulse occurs, and the block stays in IDLE after DONE.
- AW=8, DST_BASE=254, three operations: writes go to 254, 255, 0 (wrap-around).
